// File: rtl/watch_digit_if.sv
// Control and status bundle for one watch digit counter.
// The master side drives strobes and load data; the slave side is the digit.
interface watch_digit_if #(
  parameter int WIDTH = 4
);
  logic             tick_i;
  logic [1:0]       mode_i;
  logic             inc_i;
  logic             dec_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             carry_o;
  logic             div_o;
  logic             err_o;

  modport master (
    output tick_i, mode_i, inc_i, dec_i,
    output load_i, load_val_i,
    input  count_o, carry_o, div_o, err_o
  );

  modport slave (
    input  tick_i, mode_i, inc_i, dec_i,
    input  load_i, load_val_i,
    output count_o, carry_o, div_o, err_o
  );
endinterface

// File: rtl/watch_digit_counter.sv
// Modulo-N watch digit: strobe-enabled run, time-set adjust, load,
// one-cycle carry for cascading and the legacy divided square wave.
module watch_digit_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10,
  parameter int INIT   = 0
) (
  input logic clk_i,
  input logic rst_i,
  watch_digit_if.slave dig
);
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_SET  = 2'b10;

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] HALF  = WIDTH'(MODULO / 2 - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic             carry_q, carry_n;
  logic             div_q, div_n;
  logic             err_q, err_n;

  logic load_ok;
  logic at_last;
  logic at_half;
  logic run_tick;
  logic set_step;

  // Widened compare so MODULO = 2^WIDTH never overflows.
  assign load_ok  = 32'(dig.load_val_i) < 32'(MODULO);
  assign at_last  = cnt_q == LAST;
  assign at_half  = cnt_q == HALF;
  assign run_tick = (dig.mode_i == MODE_RUN) && dig.tick_i;
  assign set_step = (dig.mode_i == MODE_SET)
                  && (dig.inc_i ^ dig.dec_i);

  always_comb begin
    cnt_n   = cnt_q;
    carry_n = 1'b0;
    div_n   = div_q;
    err_n   = 1'b0;
    if (dig.load_i) begin
      if (load_ok) begin
        cnt_n = dig.load_val_i;
      end else begin
        cnt_n = '0;
        err_n = 1'b1;
      end
    end else begin
      unique case (1'b1)
        run_tick: begin
          if (at_half || at_last)
            div_n = ~div_q;
          cnt_n   = at_last ? '0 : cnt_q + 1'b1;
          carry_n = at_last;
        end
        set_step: begin
          if (dig.inc_i)
            cnt_n = at_last ? '0 : cnt_q + 1'b1;
          else
            cnt_n = (cnt_q == '0) ? LAST : cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= RST_V;
      carry_q <= 1'b0;
      div_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      carry_q <= carry_n;
      div_q   <= div_n;
      err_q   <= err_n;
    end
  end

  assign dig.count_o = cnt_q;
  assign dig.carry_o = carry_q;
  assign dig.div_o   = div_q;
  assign dig.err_o   = err_q;

  logic unused_hold;
  assign unused_hold = (MODE_HOLD == 2'b00);
endmodule

// File: tb/tb_watch_digit_counter.sv
// Scoreboard bench: decimal digit (INIT=3) and modulo-6 digit side by side.
// Stimulus pushes expected outputs; a monitor pops and compares each cycle.
module tb_watch_digit_counter;
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  typedef struct {
    int cnt;
    bit carry;
    bit div;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  watch_digit_if #(.WIDTH(4)) if0();
  watch_digit_if #(.WIDTH(3)) if1();

  watch_digit_counter #(
    .WIDTH(4), .MODULO(10), .INIT(3)
  ) u_dec (
    .clk_i(clk), .rst_i(rst), .dig(if0)
  );

  watch_digit_counter #(
    .WIDTH(3), .MODULO(6), .INIT(0)
  ) u_hex (
    .clk_i(clk), .rst_i(rst), .dig(if1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   mods[2] = '{10, 6};
  int   mc[2];
  bit   md[2];

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Reference behaviour of one digit for one clock.
  function automatic void apply(input int k, input logic [1:0] mode,
                                input bit tick, input bit inc,
                                input bit dec, input bit ld,
                                input int val);
    exp_t e;
    int   m;
    m = mods[k];
    e.carry = 1'b0;
    e.err = 1'b0;
    if (ld) begin
      if (val < m) mc[k] = val;
      else begin
        mc[k] = 0;
        e.err = 1'b1;
      end
    end else if (mode == RUN && tick) begin
      if (mc[k] == m / 2 - 1 || mc[k] == m - 1) md[k] = ~md[k];
      if (mc[k] == m - 1) begin
        mc[k] = 0;
        e.carry = 1'b1;
      end else mc[k] = mc[k] + 1;
    end else if (mode == SET && inc != dec) begin
      mc[k] = inc ? (mc[k] + 1) % m : (mc[k] + m - 1) % m;
    end
    e.cnt = mc[k];
    e.div = md[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic drive0(input logic [1:0] mode, input bit tick,
                        input bit inc, input bit dec,
                        input bit ld, input int val);
    if0.mode_i = mode;
    if0.tick_i = tick;
    if0.inc_i = inc;
    if0.dec_i = dec;
    if0.load_i = ld;
    if0.load_val_i = 4'(val);
  endtask

  task automatic drive1(input logic [1:0] mode, input bit tick,
                        input bit inc, input bit dec,
                        input bit ld, input int val);
    if1.mode_i = mode;
    if1.tick_i = tick;
    if1.inc_i = inc;
    if1.dec_i = dec;
    if1.load_i = ld;
    if1.load_val_i = 3'(val);
  endtask

  // One clock of stimulus on digit d; the other digit idles in HOLD.
  task automatic step(input int d, input logic [1:0] mode,
                      input bit tick, input bit inc, input bit dec,
                      input bit ld, input int val);
    @(negedge clk);
    if (d == 0) begin
      drive0(mode, tick, inc, dec, ld, val);
      drive1(HOLD, 0, 0, 0, 0, 0);
      apply(0, mode, tick, inc, dec, ld, val);
      apply(1, HOLD, 0, 0, 0, 0, 0);
    end else begin
      drive0(HOLD, 0, 0, 0, 0, 0);
      drive1(mode, tick, inc, dec, ld, val);
      apply(0, HOLD, 0, 0, 0, 0, 0);
      apply(1, mode, tick, inc, dec, ld, val);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d10_count", int'(if0.count_o), e.cnt);
        chk("d10_carry", int'(if0.carry_o), int'(e.carry));
        chk("d10_div", int'(if0.div_o), int'(e.div));
        chk("d10_err", int'(if0.err_o), int'(e.err));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d6_count", int'(if1.count_o), e.cnt);
        chk("d6_carry", int'(if1.carry_o), int'(e.carry));
        chk("d6_div", int'(if1.div_o), int'(e.div));
        chk("d6_err", int'(if1.err_o), int'(e.err));
      end
    end
  end

  initial begin
    drive0(HOLD, 0, 0, 0, 0, 0);
    drive1(HOLD, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("reset_count", int'(if0.count_o), 3);
    chk("reset_div", int'(if0.div_o), 1);
    chk("reset_carry", int'(if0.carry_o), 0);
    chk("reset_err", int'(if0.err_o), 0);
    chk("reset_count6", int'(if1.count_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mc = '{3, 0};
    md = '{1'b1, 1'b1};

    // 3 -> 0 in seven ticks; div flips at 4 and at 9
    repeat (7) step(0, RUN, 1, 0, 0, 0, 0);
    settle();
    chk("run7_count", int'(if0.count_o), 0);
    chk("run7_carry", int'(if0.carry_o), 1);
    chk("run7_div", int'(if0.div_o), 1);

    step(0, HOLD, 1, 1, 1, 0, 0);
    step(0, RSVD, 1, 1, 0, 0, 0);
    settle();
    chk("hold_count", int'(if0.count_o), 0);
    chk("hold_carry", int'(if0.carry_o), 0);

    // two full decimal periods: four div toggles
    repeat (20) step(0, RUN, 1, 0, 0, 0, 0);
    settle();
    chk("div20_count", int'(if0.count_o), 0);
    chk("div20_div", int'(if0.div_o), 1);

    step(0, SET, 0, 0, 1, 0, 0);
    settle();
    chk("set_dec_wrap", int'(if0.count_o), 9);
    step(0, SET, 0, 1, 0, 0, 0);
    step(0, SET, 0, 1, 1, 0, 0);
    step(0, SET, 1, 0, 0, 0, 0);
    settle();
    chk("set_count", int'(if0.count_o), 0);
    chk("set_div", int'(if0.div_o), 1);
    chk("set_carry", int'(if0.carry_o), 0);

    step(0, HOLD, 0, 0, 0, 1, 7);
    settle();
    chk("load7_count", int'(if0.count_o), 7);
    chk("load7_err", int'(if0.err_o), 0);
    step(0, HOLD, 0, 0, 0, 1, 12);
    settle();
    chk("load12_count", int'(if0.count_o), 0);
    chk("load12_err", int'(if0.err_o), 1);
    step(0, HOLD, 0, 0, 0, 0, 0);
    settle();
    chk("err_clear", int'(if0.err_o), 0);
    step(0, RUN, 1, 0, 0, 1, 5);
    settle();
    chk("load_tick_drop", int'(if0.count_o), 5);

    // modulo-6 digit: div flips at 2 and 5
    repeat (6) step(1, RUN, 1, 0, 0, 0, 0);
    settle();
    chk("m6_count", int'(if1.count_o), 0);
    chk("m6_carry", int'(if1.carry_o), 1);
    chk("m6_div", int'(if1.div_o), 1);
    step(1, HOLD, 0, 0, 0, 1, 7);
    settle();
    chk("m6_bad_load", int'(if1.err_o), 1);

    // 5 -> 9 -> wrap, then reset during the carry cycle
    repeat (5) step(0, RUN, 1, 0, 0, 0, 0);
    settle();
    chk("pre_rst_carry", int'(if0.carry_o), 1);
    chk("pre_rst_div", int'(if0.div_o), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_count", int'(if0.count_o), 3);
    chk("async_carry", int'(if0.carry_o), 0);
    chk("async_div", int'(if0.div_o), 1);
    drive0(HOLD, 0, 0, 0, 0, 0);
    drive1(HOLD, 0, 0, 0, 0, 0);
    q0.delete();
    q1.delete();
    mc = '{3, 0};
    md = '{1'b1, 1'b1};
    @(negedge clk);
    rst = 1'b0;
    step(0, RUN, 1, 0, 0, 0, 0);
    settle();
    chk("post_rst_count", int'(if0.count_o), 4);

    step(0, HOLD, 0, 0, 0, 0, 0);
    settle();
    #1;
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
